// File: rtl/seq_mul_feeder_if.sv
// seq_mul_feeder_if: operand, multiplier and product signals of the feeder
interface seq_mul_feeder_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   q_in;
  logic [WIDTH-1:0]   m_in;
  logic               mul_reset;
  logic [WIDTH-1:0]   mul_q;
  logic [WIDTH-1:0]   mul_m;
  logic               mul_bit;
  logic [2*WIDTH-1:0] mul_prod;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               busy;
  modport slave (
    input  in_valid, q_in, m_in, mul_prod, out_ready,
    output in_ready, mul_reset, mul_q, mul_m, mul_bit, out_valid, out_prod, busy
  );
  modport master (
    output in_valid, q_in, m_in, mul_prod, out_ready,
    input  in_ready, mul_reset, mul_q, mul_m, mul_bit, out_valid, out_prod, busy
  );
endinterface

// File: rtl/seq_mul_feeder.sv
// seq_mul_feeder: feeds a serial-bit multiplier one operand pair at a time and captures its product
module seq_mul_feeder #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                reset,
  seq_mul_feeder_if.slave    bus
);
  localparam int CMAX = WIDTH > SETTLE_CYCLES ? WIDTH : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SETTLE, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mm_q, mm_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      mq_q    <= '0;
      mm_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      mq_q    <= mq_d;
      mm_q    <= mm_d;
      prod_q  <= prod_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    mq_d    = mq_q;
    mm_d    = mm_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        mq_d    = bus.q_in;
        mm_d    = bus.m_in;
        sh_d    = bus.m_in;
        state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d    = sh_q >> 1;
        cnt_d   = cnt_q == CW'(WIDTH - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? SETTLE : SHIFT;
      end
      SETTLE: begin
        cnt_d   = cnt_q == CW'(SETTLE_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(SETTLE_CYCLES - 1) ? DONE : SETTLE;
        prod_d  = cnt_q == CW'(SETTLE_CYCLES - 1) ? bus.mul_prod : prod_q;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  // the serial bit is only live in SHIFT, so the multiplier sees zeros while clearing and settling
  assign bus.mul_bit   = state_q == SHIFT && sh_q[0];
  assign bus.mul_reset = reset || state_q == CLEAR;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.mul_q     = mq_q;
  assign bus.mul_m     = mm_q;
  assign bus.out_prod  = prod_q;
endmodule

// File: tb/tb_seq_mul_feeder.sv
// tb_seq_mul_feeder: directed stimulus with a product scoreboard and a behavioural serial multiplier
module tb_seq_mul_feeder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [15:0] acc;
  int   idx;
  logic [31:0] exp_q[$];
  int   acc_q[$];
  bit   seen = 0;
  seq_mul_feeder_if #(.WIDTH(8)) b();
  seq_mul_feeder #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // shift-and-add model of the downstream multiplier, driven only by the feeder's outputs
  always @(posedge clk) begin
    acc <= b.mul_reset ? 16'd0 : acc + (b.mul_bit ? (16'(b.mul_q) << idx) : 16'd0);
    idx <= b.mul_reset ? 0 : idx + 1;
  end
  assign b.mul_prod = acc;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      seen = 0;
    end else begin
      if (b.in_valid && b.in_ready) begin
        exp_q.push_back(32'(b.q_in) * 32'(b.m_in));
        acc_q.push_back(cyc);
      end
      if (b.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(b.out_valid), 0);
        else begin
          if (!seen) begin
            chk("latency", cyc - acc_q[0], 11);
            seen = 1;
          end
          if (b.out_ready) begin
            chk("product", 32'(b.out_prod), exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 0;
          end else begin
            chk("hold_prod", 32'(b.out_prod), exp_q[0]);
            chk("hold_in_ready", 32'(b.in_ready), 0);
          end
        end
      end
    end
  end
  task automatic send(input logic [7:0] q, input logic [7:0] m, input bit hold);
    logic r;
    int n = 0;
    b.q_in = q;
    b.m_in = m;
    b.in_valid = 1'b1;
    do begin
      r = b.in_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 0, 1);
    if (!hold) b.in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!b.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b.out_valid) chk("valid_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(b.in_ready && !b.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b.in_ready) chk("idle_timeout", 0, 1);
  endtask
  initial begin
    logic [7:0] mv;
    reset = 1'b1;
    b.in_valid = 1'b1;
    b.q_in = 8'd5;
    b.m_in = 8'd5;
    b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(b.in_ready), 1);
    chk("rst_out_valid", 32'(b.out_valid), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_mul_q", 32'(b.mul_q), 0);
    chk("rst_mul_m", 32'(b.mul_m), 0);
    chk("rst_mul_bit", 32'(b.mul_bit), 0);
    chk("rst_mul_reset", 32'(b.mul_reset), 1);
    chk("rst_out_prod", 32'(b.out_prod), 0);
    b.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_wins", 32'(b.busy), 0);
    mv = 8'd10;
    send(8'd20, mv, 0);
    chk("clear_mul_reset", 32'(b.mul_reset), 1);
    chk("clear_mul_bit", 32'(b.mul_bit), 0);
    chk("clear_in_ready", 32'(b.in_ready), 0);
    chk("mul_q", 32'(b.mul_q), 20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mul_bit", 32'(b.mul_bit), 32'(mv[k]));
    end
    wait_idle();
    send(8'd255, 8'd255, 0);
    wait_idle();
    send(8'd0, 8'd173, 0);
    wait_valid();
    @(negedge clk);
    chk("zero_in_ready", 32'(b.in_ready), 1);
    chk("zero_out_valid", 32'(b.out_valid), 0);
    b.out_ready = 1'b0;
    send(8'd20, 8'd10, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      b.in_valid = (i % 2) == 0;
      b.q_in = 8'd99;
      b.m_in = 8'd99;
      @(negedge clk);
      chk("bp_out_valid", 32'(b.out_valid), 1);
      chk("bp_in_ready", 32'(b.in_ready), 0);
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(b.out_valid), 0);
    chk("bp_release_ready", 32'(b.in_ready), 1);
    send(8'd100, 8'd100, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_mul_reset", 32'(b.mul_reset), 1);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_in_ready", 32'(b.in_ready), 1);
    chk("mid_out_valid", 32'(b.out_valid), 0);
    chk("mid_busy", 32'(b.busy), 0);
    chk("mid_mul_m", 32'(b.mul_m), 0);
    chk("mid_out_prod", 32'(b.out_prod), 0);
    send(8'd7, 8'd9, 0);
    wait_idle();
    send(8'd3, 8'd5, 1);
    send(8'd12, 8'd12, 1);
    send(8'd200, 8'd2, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
